// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window engine: FSM states, kernel weights
// and the saturating gradient-magnitude helper.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int K_SIDE = 1;
   localparam int K_MID  = 2;
   localparam int GRAD_W = 32;

   function automatic logic [GRAD_W-1:0] sat_mag(
      input logic signed [GRAD_W-1:0] gx,
      input logic signed [GRAD_W-1:0] gy,
      input int                       pix_w
   );
      logic [GRAD_W-1:0] ax;
      logic [GRAD_W-1:0] ay;
      logic [GRAD_W-1:0] sum;
      logic [GRAD_W-1:0] lim;
      ax  = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
      ay  = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
      sum = ax + ay;
      lim = (32'd1 << pix_w) - 32'd1;
      if (sum > lim) begin
         return lim;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/sobel_window_engine_line_buffer.sv
// Circular line buffer: dout always presents the value pushed DEPTH pushes ago.
module line_buffer #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [0:DEPTH-1];
   logic [PTR_W-1:0] ptr_r;

   assign dout = mem_r[ptr_r];

   // Storage array, deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[ptr_r] <= din;
      end
   end

   // Write/read pointer wraps at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {PTR_W{1'b0}};
      end else if (push) begin
         if (ptr_r == PTR_W'(DEPTH - 1)) begin
            ptr_r <= {PTR_W{1'b0}};
         end else begin
            ptr_r <= ptr_r + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/sobel_window_engine.sv
// Streaming 3x3 Sobel edge detector with on-chip window assembly.
// Optional binary thresholding is enabled by defining SOBEL_THRESHOLD_EN.
module sobel_window_engine
   import sobel_pkg::*;
#(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  in_pixel,
`ifdef SOBEL_THRESHOLD_EN
   input  logic [PIX_W-1:0]  thresh,
`endif
   output logic              out_valid,
   output logic [PIX_W-1:0]  out_pixel,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              frame_done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int CNT_W = COL_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0]  PRIME      = CNT_W'(IMG_W + 1);
   localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(IMG_W);

   state_t state_r;
   state_t state_nxt_s;

   logic [ADDR_W-1:0] pix_cnt_r;
   logic [CNT_W-1:0]  flush_cnt_r;
   logic [CNT_W-1:0]  ev_cnt_r;
   logic [COL_W-1:0]  col_r;
   logic [ROW_W-1:0]  row_r;
   logic [ADDR_W-1:0] addr_r;

   logic              accept_s;
   logic              event_s;
   logic              complete_s;
   logic [PIX_W-1:0]  push_pix_s;
   logic [PIX_W-1:0]  lb0_out_s;
   logic [PIX_W-1:0]  lb1_out_s;

   logic [PIX_W-1:0]  win_r [0:2][0:2];
   logic              win_valid_r;
   logic [ADDR_W-1:0] win_addr_r;
   logic              win_border_r;

   logic signed [GRAD_W-1:0] px_s [0:2][0:2];
   logic signed [GRAD_W-1:0] gx_s;
   logic signed [GRAD_W-1:0] gy_s;
   logic [GRAD_W-1:0]        mag_s;
   logic [PIX_W-1:0]         result_s;

   logic              in_ready_r;
   logic              busy_r;
   logic              frame_done_r;
   logic              out_valid_r;
   logic [PIX_W-1:0]  out_pixel_r;
   logic [ADDR_W-1:0] out_addr_r;

`ifdef SOBEL_THRESHOLD_EN
   logic [PIX_W-1:0]  thresh_r;
`endif

   // Event decode: an accepted pixel in RUN, or a zero-pixel tick in FLUSH.
   always_comb begin
      accept_s   = (state_r == ST_RUN) && in_valid;
      event_s    = accept_s || (state_r == ST_FLUSH);
      complete_s = event_s && (ev_cnt_r == PRIME);
      if (accept_s) begin
         push_pix_s = in_pixel;
      end else begin
         push_pix_s = {PIX_W{1'b0}};
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_RUN;
            else       state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (accept_s && (pix_cnt_r == LAST_ADDR)) state_nxt_s = ST_FLUSH;
            else                                      state_nxt_s = ST_RUN;
         end
         ST_FLUSH: begin
            if (flush_cnt_r == FLUSH_LAST) state_nxt_s = ST_DONE;
            else                           state_nxt_s = ST_FLUSH;
         end
         ST_DONE: begin
            // Hold until the final output strobe leaves the pipeline.
            if (out_valid_r && (out_addr_r == LAST_ADDR)) state_nxt_s = ST_IDLE;
            else                                          state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         in_ready_r   <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         in_ready_r   <= (state_nxt_s == ST_RUN);
         busy_r       <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FLUSH);
         frame_done_r <= (state_r == ST_DONE) && (state_nxt_s == ST_IDLE);
      end
   end

   // Frame counters and the location of the next window centre.
   always_ff @(posedge clk) begin
      if (rst || ((state_r == ST_IDLE) && start)) begin
         pix_cnt_r   <= {ADDR_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
         ev_cnt_r    <= {CNT_W{1'b0}};
         col_r       <= {COL_W{1'b0}};
         row_r       <= {ROW_W{1'b0}};
         addr_r      <= {ADDR_W{1'b0}};
      end else begin
         if (accept_s) pix_cnt_r <= pix_cnt_r + ADDR_W'(1);
         if (state_r == ST_FLUSH) flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         if (event_s && (ev_cnt_r != PRIME)) ev_cnt_r <= ev_cnt_r + CNT_W'(1);
         if (complete_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (col_r == LAST_COL) begin
               col_r <= {COL_W{1'b0}};
               row_r <= row_r + ROW_W'(1);
            end else begin
               col_r <= col_r + COL_W'(1);
            end
         end
      end
   end

`ifdef SOBEL_THRESHOLD_EN
   // Threshold is captured once per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         thresh_r <= {PIX_W{1'b0}};
      end else if ((state_r == ST_IDLE) && start) begin
         thresh_r <= thresh;
      end
   end
`endif

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
      .clk  (clk),
      .rst  (rst),
      .push (event_s),
      .din  (push_pix_s),
      .dout (lb0_out_s)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk  (clk),
      .rst  (rst),
      .push (event_s),
      .din  (lb0_out_s),
      .dout (lb1_out_s)
   );

   // Window shift: row 0 is the oldest line, column 2 the newest pixel.
   always_ff @(posedge clk) begin
      if (event_s) begin
         for (int r = 0; r < 3; r++) begin
            win_r[r][0] <= win_r[r][1];
            win_r[r][1] <= win_r[r][2];
         end
         win_r[0][2] <= lb1_out_s;
         win_r[1][2] <= lb0_out_s;
         win_r[2][2] <= push_pix_s;
      end
   end

   // Tag the window stage with its address and border flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid_r  <= 1'b0;
         win_addr_r   <= {ADDR_W{1'b0}};
         win_border_r <= 1'b0;
      end else begin
         win_valid_r <= complete_s;
         if (complete_s) begin
            win_addr_r   <= addr_r;
            win_border_r <= (row_r == {ROW_W{1'b0}}) || (row_r == LAST_ROW) ||
                            (col_r == {COL_W{1'b0}}) || (col_r == LAST_COL);
         end
      end
   end

   // Gradient and magnitude of the registered window.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            px_s[r][c] = GRAD_W'(win_r[r][c]);
         end
      end
      gx_s  = (K_SIDE * px_s[0][2] + K_MID * px_s[1][2] + K_SIDE * px_s[2][2]) -
              (K_SIDE * px_s[0][0] + K_MID * px_s[1][0] + K_SIDE * px_s[2][0]);
      gy_s  = (K_SIDE * px_s[2][0] + K_MID * px_s[2][1] + K_SIDE * px_s[2][2]) -
              (K_SIDE * px_s[0][0] + K_MID * px_s[0][1] + K_SIDE * px_s[0][2]);
      mag_s = sat_mag(gx_s, gy_s, PIX_W);
`ifdef SOBEL_THRESHOLD_EN
      if (mag_s >= GRAD_W'(thresh_r)) begin
         result_s = {PIX_W{1'b1}};
      end else begin
         result_s = {PIX_W{1'b0}};
      end
`else
      result_s = PIX_W'(mag_s);
`endif
   end

   // Registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_pixel_r <= {PIX_W{1'b0}};
         out_addr_r  <= {ADDR_W{1'b0}};
      end else begin
         out_valid_r <= win_valid_r;
         if (win_valid_r) begin
            out_pixel_r <= win_border_r ? {PIX_W{1'b0}} : result_s;
            out_addr_r  <= win_addr_r;
         end
      end
   end

   assign in_ready   = in_ready_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign out_valid  = out_valid_r;
   assign out_pixel  = out_pixel_r;
   assign out_addr   = out_addr_r;

endmodule

// File: tb/tb_sobel_window_engine.sv
// Randomised self-checking bench for sobel_window_engine on an 8x8 frame.
// Exercises SOBEL_THRESHOLD_EN frames when that macro is defined.
`timescale 1ns/1ps
module tb_sobel_window_engine;

   localparam int W = 8;
   localparam int H = 8;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_pixel;
   logic        out_valid;
   logic [7:0]  out_pixel;
   logic [15:0] out_addr;
   logic        busy;
   logic        frame_done;
`ifdef SOBEL_THRESHOLD_EN
   logic [7:0]  thresh;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int img [N];
   int exp_pix [N];
   int ev_cyc [N+W+1];
   int out_cnt = 0;
   int last_out_cyc = 0;
   int done_cnt = 0;
   bit checking = 1'b0;
   bit thr_on = 1'b0;
   int thr_val = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sobel_window_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
`ifdef SOBEL_THRESHOLD_EN
      .thresh     (thresh),
`endif
      .out_valid  (out_valid),
      .out_pixel  (out_pixel),
      .out_addr   (out_addr),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference Sobel value straight from the kernel definition.
   function automatic int ref_pixel(int r, int c);
      int gx = 0;
      int gy = 0;
      int mag;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int v = img[(r+dr)*W + (c+dc)];
            gx += v * dc * ((dr == 0) ? 2 : 1);
            gy += v * dr * ((dc == 0) ? 2 : 1);
         end
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
      if (thr_on) return (mag >= thr_val) ? 255 : 0;
      return mag;
   endfunction

   task automatic prepare();
      for (int i = 0; i < N; i++) exp_pix[i] = ref_pixel(i / W, i % W);
      for (int k = 0; k < N+W+1; k++) ev_cyc[k] = -1000;
      out_cnt  = 0;
      done_cnt = 0;
      checking = 1'b1;
   endtask

   task automatic fill_edge(input int lo, input int hi);
      for (int i = 0; i < N; i++) img[i] = ((i % W) < W/2) ? lo : hi;
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) img[i] = v;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
   endtask

   // Output monitor: order, value, latency and frame_done timing.
   initial begin
      forever begin
         @(negedge clk);
         if (checking && out_valid) begin
            if (out_cnt < N) begin
               check_eq("addr", int'(out_addr), out_cnt);
               check_eq("pixel", int'(out_pixel), exp_pix[out_cnt]);
               check_eq("latency", cyc - ev_cyc[out_cnt+W+1], 2);
            end else begin
               check_eq("out_count_bound", out_cnt, N-1);
            end
            last_out_cyc = cyc;
            out_cnt++;
         end
         if (checking && frame_done) begin
            check_eq("done_timing", cyc - last_out_cyc, 1);
            check_eq("done_count", out_cnt, N);
            done_cnt++;
         end
      end
   end

   task automatic start_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // gap_mode: 0 none, 1 alternate valid/idle, 2 random idle cycles.
   task automatic send_frame(input int n_send, input int gap_mode);
      for (int i = 0; i < n_send; i++) begin
         int idle;
         int b;
         idle = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
                (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         in_valid = 1'b0;
         for (int g = 0; g < idle; g++) begin
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_pixel = 8'(img[i]);
         b = 0;
         do begin
            @(negedge clk);
            b++;
         end while (!in_ready && b < 50);
         if (!in_ready) check_eq("accept_timeout", int'(in_ready), 1);
         ev_cyc[i] = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (n_send == N) begin
         for (int j = 0; j <= W; j++) ev_cyc[N+j] = ev_cyc[N-1] + 1 + j;
      end
   endtask

   task automatic wait_done();
      int b = 0;
      while (done_cnt == 0 && b < 500) begin
         @(negedge clk);
         b++;
      end
      check_eq("frame_done_seen", done_cnt, 1);
      @(negedge clk);
      check_eq("idle_busy", int'(busy), 0);
      check_eq("idle_ready", int'(in_ready), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_pixel = 8'h00;
`ifdef SOBEL_THRESHOLD_EN
      thresh  = 8'h80;
      thr_on  = 1'b1;
      thr_val = 128;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", int'(in_ready), 0);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_pixel", int'(out_pixel), 0);
      check_eq("rst_out_addr", int'(out_addr), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_frame_done", int'(frame_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Uniform frame, with in_valid driven while idle beforehand.
      fill_const(8'h10);
      prepare();
      in_valid = 1'b1;
      in_pixel = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("idle_no_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      start_frame();
      @(negedge clk);
      check_eq("run_busy", int'(busy), 1);
      check_eq("run_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      send_frame(N, 0);
      wait_done();

      // Vertical edge, then the same frame with alternating stalls.
      for (int pass = 0; pass < 2; pass++) begin
         fill_edge(0, 255);
         prepare();
         start_frame();
         send_frame(N, pass);
         wait_done();
      end

      // Random frame with random stalls and a stray start mid-RUN.
      fill_rand();
      prepare();
      start_frame();
      fork
         send_frame(N, 2);
         begin
            repeat (30) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      wait_done();

      // Abort after 20 pixels, then a complete random frame.
      checking = 1'b0;
      fill_rand();
      start_frame();
      send_frame(20, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_out_valid", int'(out_valid), 0);
      check_eq("abort_busy", int'(busy), 0);
      check_eq("abort_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      fill_rand();
      prepare();
      repeat (3) @(posedge clk);
      #1;
      start_frame();
      send_frame(N, 2);
      wait_done();

`ifdef SOBEL_THRESHOLD_EN
      // Threshold frames; thresh changes mid-frame must not matter.
      for (int pass = 0; pass < 2; pass++) begin
         fill_edge(0, (pass == 0) ? 8'h40 : 8'h10);
         thresh  = 8'h80;
         thr_val = 128;
         prepare();
         start_frame();
         thresh = 8'h00;
         send_frame(N, 0);
         wait_done();
      end
`endif

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
